read_buffer_pl: RTL

//  Word-granular read front end for the CCI-E read channel; read-side counterpart of the line-coalescing write buffer.

---
 rtl/ccie_pkg.sv | 19 +
 rtl/read_buffer_pl_if.sv | 37 +++
 rtl/line_word_select.sv | 14 +
 rtl/read_buffer_pl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ccie_pkg.sv
// Shared CCI-E read/write buffer definitions: bus widths, line geometry and
// the read-buffer FSM encoding.
package ccie_pkg;

    localparam int ADDR_LMT       = 20;
    localparam int MDATA          = 14;
    localparam int CACHE_WIDTH    = 512;
    localparam int DATA_WIDTH     = 32;
    localparam int WORDS_PER_LINE = 16;
    localparam int OFFSET_W       = $clog2(WORDS_PER_LINE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } rb_state_e;

endpackage : ccie_pkg

// File: rtl/read_buffer_pl_if.sv
// Client and CCI read-channel signals of the read buffer. The buffer itself
// uses the slave view; the surrounding system drives through the master view.
interface read_buffer_pl_if import ccie_pkg::*;;

    logic [ADDR_LMT-1:0]          rd_req_addr;
    logic [MDATA-1:0]             rd_req_mdata;
    logic                         rd_req_en;
    logic                         rd_req_almostfull;
    logic                         rd_rsp_valid;
    logic [MDATA-1:0]             rd_rsp_mdata;
    logic [CACHE_WIDTH-1:0]       rd_rsp_data;
    logic                         rd_en;
    logic [ADDR_LMT+OFFSET_W-1:0] rd_addr;
    logic [MDATA-1:0]             rd_mdata;
    logic                         rd_direct;
    logic                         rd_inval;
    logic                         rd_busy;
    logic                         rd_valid;
    logic [DATA_WIDTH-1:0]        rd_data;
    logic [CACHE_WIDTH-1:0]       rd_line;
    logic [MDATA-1:0]             rd_mdata_out;

    modport master (
        input  rd_req_addr, rd_req_mdata, rd_req_en,
               rd_busy, rd_valid, rd_data, rd_line, rd_mdata_out,
        output rd_req_almostfull, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
               rd_en, rd_addr, rd_mdata, rd_direct, rd_inval
    );

    modport slave (
        output rd_req_addr, rd_req_mdata, rd_req_en,
               rd_busy, rd_valid, rd_data, rd_line, rd_mdata_out,
        input  rd_req_almostfull, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
               rd_en, rd_addr, rd_mdata, rd_direct, rd_inval
    );

endinterface : read_buffer_pl_if

// File: rtl/line_word_select.sv
// Picks one DATA_WIDTH word out of a cache line by word offset; offset 0 is
// the least significant word.
module line_word_select import ccie_pkg::*; (
    input  logic [CACHE_WIDTH-1:0] line_i,
    input  logic [OFFSET_W-1:0]    offset_i,
    output logic [DATA_WIDTH-1:0]  word_o
);

    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] words;

    assign words  = line_i;
    assign word_o = words[offset_i];

endmodule : line_word_select

// File: rtl/read_buffer_pl.sv
// Word-granular read front end for the CCI-E read channel: one cached line,
// hits complete next cycle, misses and direct reads fetch the line over CCI.
module read_buffer_pl import ccie_pkg::*; (
    input logic             clk,
    input logic             rst,
    read_buffer_pl_if.slave bus
);

    rb_state_e                 state_q, state_d;
    logic                      line_valid_q, line_valid_d;
    logic                      inval_seen_q, inval_seen_d;
    logic [ADDR_LMT-1:0]       tag_q, tag_d;
    logic [ADDR_LMT-1:0]       lat_line_q, lat_line_d;
    logic [OFFSET_W-1:0]       lat_off_q, lat_off_d;
    logic [MDATA-1:0]          lat_mdata_q, lat_mdata_d;
    logic [CACHE_WIDTH-1:0]    line_q, line_d;

    logic                      req_en_q, req_en_d;
    logic [ADDR_LMT-1:0]       req_addr_q, req_addr_d;
    logic [MDATA-1:0]          req_mdata_q, req_mdata_d;
    logic                      valid_q, valid_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [CACHE_WIDTH-1:0]    line_out_q, line_out_d;
    logic [MDATA-1:0]          mdata_out_q, mdata_out_d;

    logic [ADDR_LMT-1:0]       cli_line;
    logic [OFFSET_W-1:0]       cli_off;
    logic [OFFSET_W-1:0]       sel_off;
    logic [DATA_WIDTH-1:0]     sel_word;
    logic                      accept, hit, rsp_match;

    assign cli_line  = bus.rd_addr[ADDR_LMT+OFFSET_W-1:OFFSET_W];
    assign cli_off   = bus.rd_addr[OFFSET_W-1:0];
    assign accept    = (state_q == ST_IDLE) && bus.rd_en;
    assign hit       = line_valid_q && (cli_line == tag_q) && !bus.rd_direct && !bus.rd_inval;
    assign rsp_match = (state_q == ST_WAIT) && bus.rd_rsp_valid && (bus.rd_rsp_mdata == lat_mdata_q);

    // Hits select from the request offset; completions use the latched one.
    assign sel_off = (state_q == ST_RESP) ? lat_off_q : cli_off;

    line_word_select u_word_sel (
        .line_i   (line_q),
        .offset_i (sel_off),
        .word_o   (sel_word)
    );

    // NOTE: reset is synchronous, so it lives inside the clocked branch, never in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept && !hit)          state_d = ST_REQ;
            ST_REQ:  if (!bus.rd_req_almostfull)  state_d = ST_WAIT;
            ST_WAIT: if (rsp_match)               state_d = ST_RESP;
            ST_RESP:                              state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every _d gets a default here so no path through the case can infer a latch.
        line_valid_d = line_valid_q && !bus.rd_inval;
        inval_seen_d = inval_seen_q || bus.rd_inval;
        tag_d        = tag_q;
        lat_line_d   = lat_line_q;
        lat_off_d    = lat_off_q;
        lat_mdata_d  = lat_mdata_q;
        line_d       = line_q;
        req_en_d     = 1'b0;
        req_addr_d   = '0;
        req_mdata_d  = '0;
        valid_d      = 1'b0;
        data_d       = '0;
        line_out_d   = '0;
        mdata_out_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && hit) begin
                    valid_d     = 1'b1;
                    data_d      = sel_word;
                    line_out_d  = line_q;
                    mdata_out_d = bus.rd_mdata;
                end else if (accept) begin
                    lat_line_d   = cli_line;
                    lat_off_d    = cli_off;
                    lat_mdata_d  = bus.rd_mdata;
                    // An invalidate alongside the request predates the fetch.
                    inval_seen_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (!bus.rd_req_almostfull) begin
                    req_en_d    = 1'b1;
                    req_addr_d  = lat_line_q;
                    req_mdata_d = lat_mdata_q;
                end
            end
            ST_WAIT: begin
                if (rsp_match) begin
                    line_d       = bus.rd_rsp_data;
                    tag_d        = lat_line_q;
                    line_valid_d = !(inval_seen_q || bus.rd_inval);
                end
            end
            ST_RESP: begin
                valid_d     = 1'b1;
                data_d      = sel_word;
                line_out_d  = line_q;
                mdata_out_d = lat_mdata_q;
            end
            default: ;
        endcase
    end

    // NOTE: the line buffer is plain flops, not a RAM, so it is cleared with everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid_q <= 1'b0;
            inval_seen_q <= 1'b0;
            tag_q        <= '0;
            lat_line_q   <= '0;
            lat_off_q    <= '0;
            lat_mdata_q  <= '0;
            line_q       <= '0;
            req_en_q     <= 1'b0;
            req_addr_q   <= '0;
            req_mdata_q  <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            line_out_q   <= '0;
            mdata_out_q  <= '0;
        end else begin
            line_valid_q <= line_valid_d;
            inval_seen_q <= inval_seen_d;
            tag_q        <= tag_d;
            lat_line_q   <= lat_line_d;
            lat_off_q    <= lat_off_d;
            lat_mdata_q  <= lat_mdata_d;
            line_q       <= line_d;
            req_en_q     <= req_en_d;
            req_addr_q   <= req_addr_d;
            req_mdata_q  <= req_mdata_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            line_out_q   <= line_out_d;
            mdata_out_q  <= mdata_out_d;
        end
    end

    assign bus.rd_req_en    = req_en_q;
    assign bus.rd_req_addr  = req_addr_q;
    assign bus.rd_req_mdata = req_mdata_q;
    assign bus.rd_valid     = valid_q;
    assign bus.rd_data      = data_q;
    assign bus.rd_line      = line_out_q;
    assign bus.rd_mdata_out = mdata_out_q;
    assign bus.rd_busy      = (state_q != ST_IDLE);

endmodule : read_buffer_pl
